// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Purpose  : Oversampled 8N1 receive deframer with framing-error and
//            line-break detection; feeds the Rx FIFO via a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deframer #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic                 break_det
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_bitIdx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_done;
    logic                   r_err;
    logic                   r_break;

    logic                   w_rxS;
    logic [2:0]             w_nextState;
    logic [CNT_W-1:0]       w_nextCnt;
    logic [IDX_W-1:0]       w_nextIdx;
    logic [DATA_BITS-1:0]   w_nextShift;
    logic                   w_stopSample;

    assign w_rxS = r_sync[SYNC_STAGES-1];

    // State register: the synchronizer runs every clock, everything else
    // only moves on sample_en; done is a pure strobe and self-clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '1;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_break  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rx};
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_bitIdx <= w_nextIdx;
            r_shift  <= w_nextShift;
            r_done   <= w_stopSample;
            r_err    <= w_stopSample & ~w_rxS;
            if (w_stopSample) begin
                r_data <= r_shift;
            end
            if (w_stopSample && (w_nextState == S_BREAK)) begin
                r_break <= 1'b1;
            end else if ((r_state == S_BREAK) && (w_nextState == S_IDLE)) begin
                r_break <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextIdx    = r_bitIdx;
        w_nextShift  = r_shift;
        w_stopSample = 1'b0;
        if (sample_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxS) begin
                        w_nextState = S_START;
                        w_nextCnt   = '0;
                        w_nextIdx   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        w_nextState = w_rxS ? S_IDLE : S_DATA;
                        w_nextCnt   = '0;
                        w_nextIdx   = '0;
                    end else begin
                        w_nextCnt = r_cnt + c_CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_FULL_LAST) begin
                        w_nextCnt   = '0;
                        w_nextShift = {w_rxS, r_shift[DATA_BITS-1:1]};
                        if (r_bitIdx == c_IDX_LAST) begin
                            w_nextState = S_STOP;
                            w_nextIdx   = '0;
                        end else begin
                            w_nextIdx = r_bitIdx + c_IDX_ONE;
                        end
                    end else begin
                        w_nextCnt = r_cnt + c_CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_FULL_LAST) begin
                        // Leaving at mid-stop lets a back-to-back start bit be caught
                        w_stopSample = 1'b1;
                        w_nextCnt    = '0;
                        w_nextIdx    = '0;
                        w_nextState  = (!w_rxS && (r_shift == '0)) ? S_BREAK : S_IDLE;
                    end else begin
                        w_nextCnt = r_cnt + c_CNT_ONE;
                    end
                end
                S_BREAK: begin
                    if (w_rxS) begin
                        w_nextState = S_IDLE;
                        w_nextCnt   = '0;
                        w_nextIdx   = '0;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                    w_nextCnt   = '0;
                    w_nextIdx   = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy      = (r_state != S_IDLE);
        data      = r_data;
        done      = r_done;
        err       = r_err;
        break_det = r_break;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deframer
// Purpose  : Randomized scoreboard bench for uart_rx_deframer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deframer;

    localparam int OVERSAMPLE  = 16;
    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_LAT   = OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sample_en;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 done;
    logic                 err;
    logic                 busy;
    logic                 break_det;

    uart_rx_deframer #(
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sample_en(sample_en),
        .rx       (rx),
        .data     (data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .break_det(break_det)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 err;
        logic                 brk;
    } exp_t;

    exp_t expQ[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   tickDiv     = 1;
    int   busyRise    = 0;
    int   busyLen     = 0;
    int   doneLat     = 0;
    int   lastDoneCyc = -1;
    int   doneGap     = 0;
    logic prevBusy    = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Oversample tick: one cycle in tickDiv
    initial begin
        int tc = 0;
        sample_en = 1'b1;
        forever begin
            @(negedge clk);
            tc++;
            sample_en = ((tc % tickDiv) == 0);
        end
    end

    // Monitor: pops the scoreboard on every done strobe
    always @(negedge clk) begin
        cyc++;
        if (busy && !prevBusy) busyRise = cyc;
        if (!busy && prevBusy) busyLen = cyc - busyRise;
        prevBusy = busy;
        if (done) begin
            doneLat = cyc - busyRise;
            if (lastDoneCyc >= 0) doneGap = cyc - lastDoneCyc;
            lastDoneCyc = cyc;
            if (expQ.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check("data", int'(data), int'(e.data));
                check("err", int'(err), int'(e.err));
                check("break_det_at_done", int'(break_det), int'(e.brk));
                check("busy_at_done", int'(busy), int'(e.brk));
            end
        end
    end

    // Reference model: a frame yields its byte, err = inverted stop bit,
    // and a break when both the byte and the stop bit are all zero.
    task automatic expectFrame(input logic [DATA_BITS-1:0] b, input logic stopBit);
        exp_t e;
        e.data = b;
        e.err  = ~stopBit;
        e.brk  = (~stopBit) && (b == '0);
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [DATA_BITS-1:0] b, input logic stopBit);
        int bc;
        bc = OVERSAMPLE * tickDiv;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = b[i];
            repeat (bc) @(negedge clk);
        end
        rx = stopBit;
        repeat (bc) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", expQ.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data", int'(data), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_break", int'(break_det), 0);
        reset = 1'b0;
        idle(20);

        // Nominal frame and latency from the detection tick
        expectFrame(8'hA5, 1'b1);
        sendFrame(8'hA5, 1'b1);
        idle(20);
        drain();
        check("done_latency", doneLat, FRAME_LAT);
        check("busy_len_frame", busyLen, FRAME_LAT);

        // Short start glitch, then a good frame
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_busy_len", busyLen, OVERSAMPLE / 2);
        expectFrame(8'h3C, 1'b1);
        sendFrame(8'h3C, 1'b1);
        idle(20);
        drain();

        // Framing error
        expectFrame(8'h3C, 1'b0);
        sendFrame(8'h3C, 1'b0);
        idle(40);
        drain();
        check("idle_after_ferr", int'(busy), 0);
        check("no_break_after_ferr", int'(break_det), 0);

        // Line break for 30 bit times
        expectFrame(8'h00, 1'b0);
        rx = 1'b0;
        repeat (30 * OVERSAMPLE) @(negedge clk);
        check("break_det_held", int'(break_det), 1);
        check("busy_in_break", int'(busy), 1);
        idle(10);
        check("break_det_cleared", int'(break_det), 0);
        check("busy_after_break", int'(busy), 0);
        expectFrame(8'h81, 1'b1);
        sendFrame(8'h81, 1'b1);
        idle(20);
        drain();

        // Reset in the middle of data bit 4
        fork
            sendFrame(8'hFF, 1'b1);
            begin
                repeat (OVERSAMPLE * 5 + OVERSAMPLE / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("busy_after_reset", int'(busy), 0);
            end
        join
        idle(20);
        expectFrame(8'h5A, 1'b1);
        sendFrame(8'h5A, 1'b1);
        idle(20);
        drain();

        // Random frames with random stop bits and gaps
        for (int n = 0; n < 12; n++) begin
            logic [DATA_BITS-1:0] b;
            logic                 s;
            b = DATA_BITS'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            expectFrame(b, s);
            sendFrame(b, s);
            idle($urandom_range(OVERSAMPLE, 4 * OVERSAMPLE));
            drain();
        end

        // Slow ticks, back-to-back frames
        tickDiv = 4;
        idle(100);
        lastDoneCyc = -1;
        expectFrame(8'h01, 1'b1);
        expectFrame(8'hFF, 1'b1);
        sendFrame(8'h01, 1'b1);
        sendFrame(8'hFF, 1'b1);
        idle(200);
        drain();
        check("back_to_back_gap", doneGap, 10 * OVERSAMPLE * 4);
        tickDiv = 1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
